// File: rtl/operand_regfile_pkg.sv
// Shared constants for the operand register bank: default geometry and the
// write-mode encoding driven onto auto_inc by the control FSM.
package operand_regfile_pkg;
  localparam int DEF_WIDTH = 5;
  localparam int DEF_DEPTH = 4;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_AUTO = 1'b1;
endpackage

// File: rtl/operand_slot.sv
// One operand entry: WIDTH-bit data plus its own valid bit. Clear beats write;
// reset is asynchronous and active-high.
module operand_slot #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (we) begin
      data_d  = d;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/operand_regfile.sv
// Operand register bank: DEPTH slots, explicit or auto-incrementing writes,
// two combinational read ports. Define OPERAND_REGFILE_BYPASS_EN for write-through reads.
module operand_regfile
  import operand_regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              auto_inc,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  Data,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  Q_a,
  output logic [WIDTH-1:0]  Q_b,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [DEPTH-1:0]  valid,
  output logic              all_valid,
  output logic              wrap
);
  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic              wrap_d, wrap_q;
  logic [ADDR_W-1:0] wr_idx;
  logic              do_write;
  logic [WIDTH-1:0]  entry [DEPTH];

  assign wr_idx   = (auto_inc == MODE_AUTO) ? wr_ptr_q : wr_addr;
  assign do_write = enable && !clear;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    operand_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (reset),
      .we    (do_write && (wr_idx == ADDR_W'(i))),
      .clr   (clear),
      .d     (Data),
      .q     (entry[i]),
      .valid (valid[i])
    );
  end

  // The pointer only moves on auto writes; addressed writes leave it alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wrap_d   = wrap_q;
    if (clear) begin
      wr_ptr_d = '0;
      wrap_d   = 1'b0;
    end else if (enable && (auto_inc == MODE_AUTO)) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == ADDR_W'(DEPTH - 1)) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef OPERAND_REGFILE_BYPASS_EN
  // Forward the in-flight write; suppressed while reset holds the bank empty.
  always_comb begin
    Q_a = entry[rd_addr_a];
    Q_b = entry[rd_addr_b];
    if (do_write && !reset && (rd_addr_a == wr_idx)) Q_a = Data;
    if (do_write && !reset && (rd_addr_b == wr_idx)) Q_b = Data;
  end
`else
  assign Q_a = entry[rd_addr_a];
  assign Q_b = entry[rd_addr_b];
`endif

  assign wr_ptr    = wr_ptr_q;
  assign wrap      = wrap_q;
  assign all_valid = &valid;
endmodule

// File: tb/tb_operand_regfile.sv
// Directed plus randomized bench for operand_regfile (WIDTH=5, DEPTH=4)
// against an array-based reference model.
module tb_operand_regfile;
  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              auto_inc;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  Data;
  logic              clear;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  Q_a;
  logic [WIDTH-1:0]  Q_b;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DEPTH-1:0]  valid;
  logic              all_valid;
  logic              wrap;

  int checks = 0;
  int errors = 0;

  // reference model
  int  m_mem [DEPTH];
  bit  m_valid [DEPTH];
  int  m_ptr;
  bit  m_wrap;

  always #5 clk = ~clk;

  operand_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .auto_inc  (auto_inc),
    .wr_addr   (wr_addr),
    .Data      (Data),
    .clear     (clear),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .Q_a       (Q_a),
    .Q_b       (Q_b),
    .wr_ptr    (wr_ptr),
    .valid     (valid),
    .all_valid (all_valid),
    .wrap      (wrap)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = 0;
      m_valid[i] = 0;
    end
    m_ptr  = 0;
    m_wrap = 0;
  endtask

  // Applies one rising edge worth of the documented behaviour.
  task automatic model_edge();
    int idx;
    if (reset) return;
    if (clear) begin
      model_reset();
    end else if (enable) begin
      idx = auto_inc ? m_ptr : int'(wr_addr);
      m_mem[idx]   = int'(Data);
      m_valid[idx] = 1;
      if (auto_inc) begin
        if (m_ptr == DEPTH - 1) m_wrap = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
  endtask

  function automatic int exp_q(input int ra);
    int r;
    r = m_mem[ra];
`ifdef OPERAND_REGFILE_BYPASS_EN
    if (enable && !clear && !reset && ra == (auto_inc ? m_ptr : int'(wr_addr)))
      r = int'(Data);
`endif
    return r;
  endfunction

  task automatic check_all(input string tag);
    int vbits;
    bit allv;
    vbits = 0;
    allv  = 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i]) vbits |= (1 << i);
      else allv = 0;
    end
    chk({tag, ".Q_a"},       int'(Q_a),       exp_q(int'(rd_addr_a)));
    chk({tag, ".Q_b"},       int'(Q_b),       exp_q(int'(rd_addr_b)));
    chk({tag, ".valid"},     int'(valid),     vbits);
    chk({tag, ".all_valid"}, int'(all_valid), int'(allv));
    chk({tag, ".wr_ptr"},    int'(wr_ptr),    m_ptr);
    chk({tag, ".wrap"},      int'(wrap),      int'(m_wrap));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic sweep_reads(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_a = ADDR_W'(a);
      rd_addr_b = ADDR_W'(DEPTH - 1 - a);
      #1;
      check_all(tag);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] load_vals [4];
    load_vals[0] = 5'h03; load_vals[1] = 5'h1F;
    load_vals[2] = 5'h0A; load_vals[3] = 5'h11;

    reset = 1'b1; enable = 1'b0; auto_inc = 1'b0; wr_addr = '0;
    Data = '0; clear = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_init");
    reset = 1'b0;

    // auto load four operands
    auto_inc = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Data = load_vals[i];
      rd_addr_a = ADDR_W'(i);
      rd_addr_b = ADDR_W'($urandom_range(0, DEPTH - 1));
      cyc("auto_load");
    end
    enable = 1'b0;
    #1;
    sweep_reads("auto_load_sweep");
    chk("auto_load.wrap_set", int'(wrap), 1);
    chk("auto_load.all_valid", int'(all_valid), 1);
    chk("auto_load.entry3", int'(m_mem[3]), 5'h11);

    enable = 1'b1; Data = 5'h07;
    cyc("auto_overwrite");
    enable = 1'b0;
    rd_addr_a = '0; rd_addr_b = 2'd1;
    #1;
    check_all("auto_overwrite_rd");
    chk("auto_overwrite.entry0", int'(Q_a), 5'h07);

    // addressed write never moves wr_ptr
    enable = 1'b1; auto_inc = 1'b0; wr_addr = 2'd2; Data = 5'h15;
    rd_addr_a = 2'd2; rd_addr_b = 2'd2;
    cyc("addr_write");
    enable = 1'b0;
    #1;
    check_all("addr_write_rd");
    chk("addr_write.Q_a", int'(Q_a), 5'h15);
    chk("addr_write.Q_b", int'(Q_b), 5'h15);
    chk("addr_write.wr_ptr", int'(wr_ptr), 1);

    // same-cycle visibility: bypass shows Data, otherwise old contents
    rd_addr_a = 2'd3; rd_addr_b = 2'd0;
    enable = 1'b1; auto_inc = 1'b0; wr_addr = 2'd3; Data = 5'h09;
    #1;
    check_all("bypass_pre_edge");
`ifdef OPERAND_REGFILE_BYPASS_EN
    chk("bypass.Q_a_same_cycle", int'(Q_a), 5'h09);
`else
    chk("bypass.Q_a_old", int'(Q_a), 5'h11);
`endif
    cyc("bypass_edge");
    enable = 1'b0;
    #1;
    chk("bypass.Q_a_after", int'(Q_a), 5'h09);

    // hold: enable low, other inputs toggle
    for (int i = 0; i < 20; i++) begin
      enable = 1'b0;
      auto_inc = 1'($urandom_range(0, 1));
      wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      Data = WIDTH'($urandom_range(0, 31));
      rd_addr_a = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd_addr_b = ADDR_W'($urandom_range(0, DEPTH - 1));
      cyc("hold");
    end

    // clear beats enable
    enable = 1'b1; clear = 1'b1; auto_inc = 1'b1; Data = 5'h1E;
    cyc("clear_prio");
    clear = 1'b0; enable = 1'b0;
    #1;
    sweep_reads("clear_sweep");
    chk("clear.valid", int'(valid), 0);
    chk("clear.wrap", int'(wrap), 0);

    // randomized mixed traffic
    for (int i = 0; i < 300; i++) begin
      clear = ($urandom_range(0, 31) == 0);
      enable = 1'($urandom_range(0, 1));
      auto_inc = 1'($urandom_range(0, 1));
      wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      Data = WIDTH'($urandom);
      rd_addr_a = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd_addr_b = ADDR_W'($urandom_range(0, DEPTH - 1));
      cyc("random");
    end
    clear = 1'b0;

    // async reset in the middle of a write
    enable = 1'b1; auto_inc = 1'b1; Data = 5'h1B;
    rd_addr_a = 2'd1; rd_addr_b = 2'd2;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid");
    chk("reset_mid.Q_a", int'(Q_a), 0);
    #2;
    reset = 1'b0;
    Data = 5'h0C; rd_addr_a = 2'd0;
    cyc("post_reset_write");
    chk("post_reset.wr_ptr", int'(wr_ptr), 1);
    enable = 1'b0;
    #1;
    chk("post_reset.entry0", int'(Q_a), 5'h0C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
